// File: rtl/esm_pkg.sv
// Shared definitions for the ESM instruction buffer: reader FSM states
// and ring-index arithmetic common to the writer and reader sides.
package esm_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_BS = 16;

  // Ring occupancy with natural wrap; depth is a power of two, so masking
  // the 32-bit difference is the same as wrapping in $clog2(depth) bits.
  function automatic logic [31:0] ring_occ(input logic [31:0] wr_idx,
                                           input logic [31:0] rd_idx,
                                           input int unsigned depth);
    return (wr_idx - rd_idx) & (depth - 32'd1);
  endfunction

  function automatic bit bs_is_valid(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/ring_occupancy.sv
// Occupancy, empty and full flags of a power-of-two ring, shared by the
// ESM writer and reader.
module ring_occupancy
  import esm_pkg::*;
#(
  parameter int unsigned bs = DEFAULT_BS
) (
  input  logic [$clog2(bs)-1:0] wr_index,
  input  logic [$clog2(bs)-1:0] rd_index,
  output logic                  empty,
  output logic                  buf_full
);

  localparam int IDX_W = $clog2(bs);

  logic [IDX_W-1:0] occupancy;

  assign occupancy = IDX_W'(ring_occ(32'(wr_index), 32'(rd_index), bs));
  assign empty     = (occupancy == '0);
  // One slot stays unused so that full and empty remain distinguishable.
  assign buf_full  = (occupancy == IDX_W'(bs - 1));

endmodule

// File: rtl/instr_buffer_reader.sv
// Drains the ESM instruction ring in program order, retires bubble slots
// and presents real instructions on a valid/ready port.
module instr_buffer_reader
  import esm_pkg::*;
#(
  parameter int unsigned Instruction_word_size = 32,
  parameter int unsigned bs                    = DEFAULT_BS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [$clog2(bs)-1:0]            wr_index,
  input  logic [0:bs-1]                    valid_entries,
  input  logic [Instruction_word_size-1:0] buf_rd_data,
  output logic [$clog2(bs)-1:0]            rd_index,
  output logic [0:bs-1]                    clr_valid,
  output logic [Instruction_word_size-1:0] Instr_out,
  output logic                             out_valid,
  input  logic                             out_ready,
  input  logic                             flush,
  output logic                             empty,
  output logic                             buf_full
);

  localparam int IDX_W = $clog2(bs);

  if (!bs_is_valid(bs)) begin : g_bad_bs
    $error("instr_buffer_reader: bs must be a power of two and at least 2");
  end

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 rd_index_q, rd_index_d;
  logic [Instruction_word_size-1:0] instr_q, instr_d;
  logic                             out_valid_q, out_valid_d;
  logic [0:bs-1]                    clr_valid_q, clr_valid_d;

  ring_occupancy #(.bs(bs)) u_occ (
    .wr_index (wr_index),
    .rd_index (rd_index_q),
    .empty    (empty),
    .buf_full (buf_full)
  );

  always_comb begin
    // NOTE: every signal gets a hold/idle default before any branch, so no
    // path through this block leaves a value unassigned and infers a latch.
    state_d     = state_q;
    rd_index_d  = rd_index_q;
    instr_d     = instr_q;
    out_valid_d = out_valid_q;
    clr_valid_d = '0;

    if (flush) begin
      // Flush outranks a same-cycle handshake; the all-ones strobe also
      // covers the slot that would have been retired.
      rd_index_d  = wr_index;
      clr_valid_d = '1;
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            if (valid_entries[rd_index_q]) begin
              instr_d     = buf_rd_data;
              out_valid_d = 1'b1;
              state_d     = PRESENT;
            end else begin
              clr_valid_d[rd_index_q] = 1'b1;
              rd_index_d              = rd_index_q + IDX_W'(1);
            end
          end
        end
        PRESENT: begin
          if (out_ready) begin
            clr_valid_d[rd_index_q] = 1'b1;
            rd_index_d              = rd_index_q + IDX_W'(1);
            out_valid_d             = 1'b0;
            state_d                 = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_index_q  <= '0;
      instr_q     <= '0;
      out_valid_q <= 1'b0;
      clr_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_index_q  <= rd_index_d;
      instr_q     <= instr_d;
      out_valid_q <= out_valid_d;
      clr_valid_q <= clr_valid_d;
    end
  end

  assign rd_index  = rd_index_q;
  assign Instr_out = instr_q;
  assign out_valid = out_valid_q;
  assign clr_valid = clr_valid_q;

endmodule

// File: tb/tb_instr_buffer_reader.sv
// Self-checking bench for instr_buffer_reader: directed scenarios plus a
// randomized writer/consumer run checked against an in-order queue model.
module tb_instr_buffer_reader;

  localparam int BS = 16;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    wr_index;
  logic [0:BS-1] valid_bits;
  logic [W-1:0]  buf_rd_data;
  logic [3:0]    rd_index;
  logic [0:BS-1] clr_valid;
  logic [W-1:0]  instr_out;
  logic          out_valid;
  logic          out_ready;
  logic          flush;
  logic          empty;
  logic          buf_full;

  logic [W-1:0]  mem [BS];
  logic [W-1:0]  exp_q [$];
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  assign buf_rd_data = mem[rd_index];

  instr_buffer_reader #(.Instruction_word_size(W), .bs(BS)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_index      (wr_index),
    .valid_entries (valid_bits),
    .buf_rd_data   (buf_rd_data),
    .rd_index      (rd_index),
    .clr_valid     (clr_valid),
    .Instr_out     (instr_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .flush         (flush),
    .empty         (empty),
    .buf_full      (buf_full)
  );

  function automatic logic [0:BS-1] onehot(input int i);
    logic [0:BS-1] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_instr();
    logic [W-1:0] d;
    d = $urandom;
    if (d == '0) d = 32'h1;
    return d;
  endfunction

  // Writer: deposit one word at wr_index; all-zero words are bubbles.
  task automatic write_slot(input logic [W-1:0] d);
    mem[wr_index]        = d;
    valid_bits[wr_index] = (d != '0);
    wr_index             = wr_index + 4'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; wr_index = '0; valid_bits = '0;
    for (int i = 0; i < BS; i++) mem[i] = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] d;
    do_reset();
    n_cmp++; if (rd_index !== 4'd0) begin n_bad++; $display("FAIL rst_rd_index: got %0d want 0", rd_index); end
    n_cmp++; if (instr_out !== '0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", instr_out); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (clr_valid !== '0) begin n_bad++; $display("FAIL rst_clr_valid: got %h want 0", clr_valid); end
    n_cmp++; if ({empty, buf_full} !== 2'b10) begin n_bad++; $display("FAIL rst_flags: got %b%b want 10", empty, buf_full); end
    d = rand_instr();
    write_slot(d);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_present: got %b want 1", out_valid); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || instr_out !== '0 || rd_index !== 4'd0 || clr_valid !== '0) begin
      n_bad++; $display("FAIL rst_async: got v=%b i=%h rd=%0d clr=%h want all zero", out_valid, instr_out, rd_index, clr_valid);
    end
    @(negedge clk);
    wr_index = '0; valid_bits = '0; rst = 1'b0;
  endtask

  task automatic test_single();
    mem[0] = '0; write_slot(32'h00A00093); out_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || instr_out !== 32'h00A00093) begin
      n_bad++; $display("FAIL single_present: got v=%b i=%h want 1/00a00093", out_valid, instr_out);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || instr_out !== 32'h00A00093 || rd_index !== 4'd0) begin
        n_bad++; $display("FAIL single_stall%0d: got v=%b i=%h rd=%0d want 1/00a00093/0", c, out_valid, instr_out, rd_index);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (clr_valid !== onehot(0)) begin n_bad++; $display("FAIL single_clr: got %h want %h", clr_valid, onehot(0)); end
    n_cmp++; if (rd_index !== 4'd1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_done: got rd=%0d v=%b want 1/0", rd_index, out_valid);
    end
    @(negedge clk);
    n_cmp++; if (clr_valid !== '0) begin n_bad++; $display("FAIL single_clr_pulse: got %h want 0", clr_valid); end
  endtask

  task automatic test_bubbles();
    logic [W-1:0] d;
    write_slot(rand_instr()); out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (rd_index !== 4'd2) begin n_bad++; $display("FAIL bub_start: got %0d want 2", rd_index); end
    d = rand_instr();
    write_slot('0); write_slot('0); write_slot(d);
    for (int s = 2; s < 4; s++) begin
      @(negedge clk);
      n_cmp++; if (clr_valid !== onehot(s) || rd_index !== 4'(s + 1) || out_valid !== 1'b0) begin
        n_bad++; $display("FAIL bub_retire%0d: got clr=%h rd=%0d v=%b want %h/%0d/0", s, clr_valid, rd_index, out_valid, onehot(s), s + 1);
      end
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || instr_out !== d || rd_index !== 4'd4 || clr_valid !== '0) begin
      n_bad++; $display("FAIL bub_present: got v=%b i=%h rd=%0d clr=%h want 1/%h/4/0", out_valid, instr_out, rd_index, clr_valid, d);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (rd_index !== 4'd5) begin n_bad++; $display("FAIL bub_done: got %0d want 5", rd_index); end
  endtask

  // Consume everything in exp_q with out_ready held high.
  task automatic drain(input string name, input int budget);
    out_ready = 1'b1;
    for (int c = 0; c < budget && (exp_q.size() > 0 || !empty); c++) begin
      @(negedge clk);
      if (out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL %s_extra: got %h want nothing", name, instr_out); end
        else begin
          if (instr_out !== exp_q[0]) begin n_bad++; $display("FAIL %s_order: got %h want %h", name, instr_out, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (exp_q.size() != 0 || empty !== 1'b1) begin
      n_bad++; $display("FAIL %s_drained: got left=%0d empty=%b want 0/1", name, exp_q.size(), empty);
    end
  endtask

  task automatic test_wrap_full();
    logic [W-1:0] d;
    for (int s = 5; s < 14; s++) write_slot('0);
    for (int c = 0; c < 20 && rd_index != 4'd14; c++) @(negedge clk);
    n_cmp++; if (rd_index !== 4'd14) begin n_bad++; $display("FAIL wrap_start: got %0d want 14", rd_index); end
    for (int k = 0; k < 15; k++) begin d = rand_instr(); exp_q.push_back(d); write_slot(d); end
    #1;
    n_cmp++; if (buf_full !== 1'b1 || empty !== 1'b0) begin n_bad++; $display("FAIL wrap_full: got full=%b empty=%b want 1/0", buf_full, empty); end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || instr_out !== exp_q[0] || buf_full !== 1'b1) begin
      n_bad++; $display("FAIL wrap_first: got v=%b i=%h full=%b want 1/%h/1", out_valid, instr_out, buf_full, exp_q[0]);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    n_cmp++; if (rd_index !== 4'd15 || buf_full !== 1'b0 || clr_valid !== onehot(14)) begin
      n_bad++; $display("FAIL wrap_after_hs: got rd=%0d full=%b clr=%h want 15/0/%h", rd_index, buf_full, clr_valid, onehot(14));
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || instr_out !== exp_q[0]) begin
      n_bad++; $display("FAIL wrap_slot15: got v=%b i=%h want 1/%h", out_valid, instr_out, exp_q[0]);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    n_cmp++; if (rd_index !== 4'd0) begin n_bad++; $display("FAIL wrap_to_zero: got %0d want 0", rd_index); end
    drain("wrap", 60);
    n_cmp++; if (rd_index !== 4'd13) begin n_bad++; $display("FAIL wrap_end: got %0d want 13", rd_index); end
  endtask

  task automatic test_flush();
    logic [W-1:0] d;
    d = rand_instr();
    write_slot(d);
    for (int k = 0; k < 11; k++) write_slot(rand_instr());
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || wr_index !== 4'd9) begin n_bad++; $display("FAIL flush_setup: got v=%b wr=%0d want 1/9", out_valid, wr_index); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || rd_index !== 4'd9 || clr_valid !== '1 || empty !== 1'b1) begin
      n_bad++; $display("FAIL flush_effect: got v=%b rd=%0d clr=%h empty=%b want 0/9/ffff/1", out_valid, rd_index, clr_valid, empty);
    end
    n_cmp++; if (instr_out !== d) begin n_bad++; $display("FAIL flush_hold: got %h want %h", instr_out, d); end
    @(negedge clk);
    n_cmp++; if (clr_valid !== '0 || rd_index !== 4'd9 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_after: got clr=%h rd=%0d v=%b want 0/9/0", clr_valid, rd_index, out_valid);
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 3; k++) write_slot(rand_instr());
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL simul_setup: got %b want 1", out_valid); end
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    n_cmp++; if (rd_index !== 4'd12 || out_valid !== 1'b0 || clr_valid !== '1) begin
      n_bad++; $display("FAIL simul_effect: got rd=%0d v=%b clr=%h want 12/0/ffff", rd_index, out_valid, clr_valid);
    end
    @(negedge clk);
    n_cmp++; if (rd_index !== 4'd12 || out_valid !== 1'b0 || empty !== 1'b1) begin
      n_bad++; $display("FAIL simul_after: got rd=%0d v=%b empty=%b want 12/0/1", rd_index, out_valid, empty);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (rd_index !== 4'd12 || clr_valid !== '1) begin
      n_bad++; $display("FAIL flush_empty: got rd=%0d clr=%h want 12/ffff", rd_index, clr_valid);
    end
  endtask

  task automatic test_random();
    logic         prev_valid, prev_ready;
    logic [W-1:0] prev_instr, d;
    int           occ;
    do_reset();
    prev_valid = 1'b0; prev_ready = 1'b0; prev_instr = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      valid_bits = valid_bits & ~clr_valid;
      if (prev_valid && !prev_ready) begin
        n_cmp++; if (out_valid !== 1'b1 || instr_out !== prev_instr) begin
          n_bad++; $display("FAIL rnd_stable@%0d: got v=%b i=%h want 1/%h", cyc, out_valid, instr_out, prev_instr);
        end
      end
      occ = (int'(wr_index) - int'(rd_index) + BS) % BS;
      n_cmp++; if (empty !== (occ == 0) || buf_full !== (occ == BS - 1)) begin
        n_bad++; $display("FAIL rnd_flags@%0d: got e=%b f=%b want occ=%0d", cyc, empty, buf_full, occ);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL rnd_extra@%0d: got %h want nothing", cyc, instr_out); end
        else begin
          if (instr_out !== exp_q[0]) begin n_bad++; $display("FAIL rnd_order@%0d: got %h want %h", cyc, instr_out, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      if (occ < BS - 1 && $urandom_range(0, 1) == 1) begin
        d = ($urandom_range(0, 3) == 0) ? '0 : rand_instr();
        if (d != '0) exp_q.push_back(d);
        write_slot(d);
      end
      prev_valid = out_valid; prev_ready = out_ready; prev_instr = instr_out;
    end
    drain("rnd", 200);
  endtask

  initial begin
    test_reset();
    test_single();
    test_bubbles();
    test_wrap_full();
    test_flush();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_buffer_reader.md
# instr_buffer_reader

Read-side companion to the ESM instruction buffer. The writer deposits instructions into a `bs`-entry ring and marks each slot in `valid_entries`. This block drains that ring in program order and silently retires bubble slots (all-zero instructions). It presents each real instruction on a valid/ready output port and tells the writer which slots to free and when the ring is full.

## Interface
Parameters:
- `Instruction_word_size`, default 32: instruction width in bits.
- `bs`, default 16: ring depth. Must be a power of two, at least 2.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  **reset is asynchronous and active-high**; one clock domain only.
- `wr_index`  in  $clog2(bs)  writer's next write slot.
- `valid_entries`  in  [0:bs-1]  per-slot valid bits, registered by the writer.
- `buf_rd_data`  in  Instruction_word_size  combinational buffer read of slot `rd_index`.
- `rd_index`  out  $clog2(bs)  reader's current slot.
- `clr_valid`  out  [0:bs-1]  one-cycle clear strobe to the writer's valid bits.
- `Instr_out`  out  Instruction_word_size  registered instruction.
- `out_valid`  out  1  `Instr_out` holds an instruction.
- `out_ready`  in  1  downstream accepts `Instr_out`.
- `flush`  in  1  synchronous discard of all pending slots.
- `empty`  out  1  `occupancy == 0`.
- `buf_full`  out  1  `occupancy == bs-1`; the writer must not advance while this is high.

## Operation
Occupancy:
- `occupancy = (wr_index - rd_index) mod bs`, computed in $clog2(bs) bits with natural wrap.
- Usable capacity is `bs-1` slots.

FSM states are IDLE and PRESENT.

IDLE:
- If `occupancy == 0`, hold.
- If the slot is pending and `valid_entries[rd_index] == 1`:
  - latch `buf_rd_data` into `Instr_out`;
  - set `out_valid`;
  - go to PRESENT.
- If the slot is pending and `valid_entries[rd_index] == 0` (bubble):
  - pulse `clr_valid[rd_index]`;
  - increment `rd_index`;
  - stay in IDLE.
  - One bubble is retired per cycle.

PRESENT:
- `Instr_out` and `out_valid` are held stable until `out_ready`.
- On `out_valid & out_ready`:
  - pulse `clr_valid[rd_index]`;
  - increment `rd_index`;
  - clear `out_valid`;
  - go to IDLE.

Flush, in any state:
- `rd_index <= wr_index`.
- `clr_valid` is all ones for one cycle.
- `out_valid <= 0`; `Instr_out` is held.
- Go to IDLE.

Outputs:
- `clr_valid` is zero in every cycle not listed above.

## Timing
- Reset values:
  - `rd_index = 0`, `Instr_out = 0`, `out_valid = 0`, `clr_valid = 0`;
  - state = IDLE;
  - `empty` and `buf_full` follow from the inputs.
- Latency: a valid slot that becomes pending at edge N gives `out_valid = 1` after edge N+1.
- Throughput: one instruction per 2 cycles with `out_ready` held high.
- `empty` and `buf_full` are combinational from `wr_index` and `rd_index`.
- Wrap-around: `rd_index` goes from `bs-1` to 0 with no special case.
- Flush together with a handshake: flush wins. No separate single-slot clear; the all-ones mask covers it.
- Flush with `occupancy == 0`: still pulses all-ones `clr_valid`; `rd_index` is unchanged.
- Reset mid-operation drops any presented instruction immediately (asynchronous).
- The writer's valid bit and `wr_index` update on the same edge, so a slot is never seen pending with a stale valid bit.

## Structure
Shared package `esm_pkg`:
- FSM state enum (IDLE, PRESENT);
- a function computing occupancy from two indices;
- the `bs` power-of-two check constant.

Sub-modules:
- One natural sub-module, `ring_occupancy`: computes occupancy, `empty` and `buf_full` from `wr_index` and `rd_index`. The ESM writer reuses it.
- Everything else is a single always block plus output registers.

## Test plan
- **Reset:** assert `rst` asynchronously mid-PRESENT.
  - All outputs go to their reset values before the next edge.
  - `rd_index = 0`.
- **Single instruction:** `wr_index` 0 to 1, `valid_entries[0] = 1`, `buf_rd_data = 32'h00A00093`.
  - `out_valid` after 1 edge with `Instr_out = 32'h00A00093`.
  - Stalled 3 cycles by `out_ready = 0`, value held.
  - On handshake, `clr_valid[0]` pulses and `rd_index = 1`.
- **Bubbles:** slots 2..4 with valid bits 0,0,1.
  - Two `clr_valid` pulses on consecutive cycles, then slot 4 is presented.
  - `rd_index` steps 2, 3, 4.
- **Wrap and full:** `rd_index = 14`, writer fills to `wr_index = 13`.
  - `buf_full = 1` (occupancy 15).
  - After the first handshake, `buf_full = 0`.
  - `rd_index` goes 15 to 0.
- **Flush:** flush while PRESENT with `wr_index = 9`.
  - Next cycle: `out_valid = 0`, `rd_index = 9`, `clr_valid` all ones for 1 cycle, `empty = 1`.
- **Simultaneous:** flush and `out_ready` high in the same cycle.
  - Flush behaviour only; no extra `rd_index` increment beyond `wr_index`.
